// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: primary WB writes always win; late load results queue in a
// small FIFO, drain into idle port cycles, and are squashed by younger primary writes to the same register.
module regfile_wb_arbiter #(
   parameter int unsigned REGISTER_LEN    = 32,
   parameter int unsigned REG_ADDRESS_LEN = 4,
   parameter int unsigned DEPTH           = 2,
   parameter int unsigned STARVE_LIMIT    = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wb_en,
   input  logic [REG_ADDRESS_LEN-1:0] wb_address,
   input  logic [REGISTER_LEN-1:0]    wb_data,
   input  logic                       ld_valid,
   input  logic [REG_ADDRESS_LEN-1:0] ld_address,
   input  logic [REGISTER_LEN-1:0]    ld_data,
   output logic                       ld_ready,
   input  logic [REG_ADDRESS_LEN-1:0] src1,
   input  logic [REG_ADDRESS_LEN-1:0] src2,
   input  logic                       two_src,
   output logic                       reg_file_wb_en,
   output logic [REG_ADDRESS_LEN-1:0] reg_file_wb_address,
   output logic [REGISTER_LEN-1:0]    reg_file_wb_data,
   output logic                       pending_hazard,
   output logic                       stall_req
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   logic [REG_ADDRESS_LEN-1:0] addr_q [DEPTH];
   logic [REG_ADDRESS_LEN-1:0] addr_d [DEPTH];
   logic [REGISTER_LEN-1:0]    data_q [DEPTH];
   logic [REGISTER_LEN-1:0]    data_d [DEPTH];
   logic [DEPTH-1:0]           vld_q, vld_d;
   logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]              count_q, count_d;
   logic [SW-1:0]              starve_q, starve_d;
   logic                       hold_q, hold_d;
   logic                       out_en_q, out_en_d;
   logic                       out_fifo_q, out_fifo_d;
   logic [REG_ADDRESS_LEN-1:0] out_addr_q, out_addr_d;
   logic [REGISTER_LEN-1:0]    out_data_q, out_data_d;

   logic full, empty, head_vld, push, pop;

   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign head_vld = ~empty & vld_q[rd_ptr_q];
   assign push     = ld_valid & ~full;
   assign pop      = ~wb_en & ~empty;

   assign ld_ready            = ~full;
   assign reg_file_wb_en      = out_en_q;
   assign reg_file_wb_address = out_addr_q;
   assign reg_file_wb_data    = out_data_q;

   // Stall latches once raised and only releases when the queue has fully drained.
   assign stall_req = (starve_q == SW'(STARVE_LIMIT)) | full |
                      (hold_q & ~(empty & (starve_q == '0)));
   assign hold_d    = stall_req;

   always_comb begin
      pending_hazard = out_en_q & out_fifo_q &
                       ((out_addr_q == src1) | (two_src & (out_addr_q == src2)));
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (vld_q[i] & ((addr_q[i] == src1) | (two_src & (addr_q[i] == src2))))
            pending_hazard = 1'b1;
      end
   end

   always_comb begin
      addr_d   = addr_q;
      data_d   = data_q;
      vld_d    = vld_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);

      // Squash first so an entry enqueued this cycle is judged against the same primary write.
      if (wb_en) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (addr_q[i] == wb_address) vld_d[i] = 1'b0;
         end
      end
      if (pop) begin
         vld_d[rd_ptr_q] = 1'b0;
         rd_ptr_d        = rd_ptr_q + PW'(1);
      end
      if (push) begin
         addr_d[wr_ptr_q] = ld_address;
         data_d[wr_ptr_q] = ld_data;
         vld_d[wr_ptr_q]  = ~(wb_en & (ld_address == wb_address));
         wr_ptr_d         = wr_ptr_q + PW'(1);
      end

      out_addr_d = out_addr_q;
      out_data_d = out_data_q;
      out_en_d   = 1'b0;
      out_fifo_d = 1'b0;
      if (wb_en) begin
         out_en_d   = 1'b1;
         out_addr_d = wb_address;
         out_data_d = wb_data;
      end else if (pop & head_vld) begin
         out_en_d   = 1'b1;
         out_fifo_d = 1'b1;
         out_addr_d = addr_q[rd_ptr_q];
         out_data_d = data_q[rd_ptr_q];
      end

      starve_d = starve_q;
      if (empty | pop)
         starve_d = '0;
      else if (head_vld & (starve_q != SW'(STARVE_LIMIT)))
         starve_d = starve_q + SW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q     <= '{default: '0};
         data_q     <= '{default: '0};
         vld_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         starve_q   <= '0;
         hold_q     <= 1'b0;
         out_en_q   <= 1'b0;
         out_fifo_q <= 1'b0;
         out_addr_q <= '0;
         out_data_q <= '0;
      end else begin
         addr_q     <= addr_d;
         data_q     <= data_d;
         vld_q      <= vld_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         starve_q   <= starve_d;
         hold_q     <= hold_d;
         out_en_q   <= out_en_d;
         out_fifo_q <= out_fifo_d;
         out_addr_q <= out_addr_d;
         out_data_q <= out_data_d;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic, all checked
// against a queue-based reference model of the arbitration rules.
module tb_regfile_wb_arbiter;

   localparam int DEPTH = 2;
   localparam int LIM   = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_en;
   logic [3:0]  wb_address;
   logic [31:0] wb_data;
   logic        ld_valid;
   logic [3:0]  ld_address;
   logic [31:0] ld_data;
   logic        ld_ready;
   logic [3:0]  src1, src2;
   logic        two_src;
   logic        reg_file_wb_en;
   logic [3:0]  reg_file_wb_address;
   logic [31:0] reg_file_wb_data;
   logic        pending_hazard;
   logic        stall_req;

   regfile_wb_arbiter #(
      .REGISTER_LEN(32),
      .REG_ADDRESS_LEN(4),
      .DEPTH(DEPTH),
      .STARVE_LIMIT(LIM)
   ) dut (
      .clk(clk), .rst(rst),
      .wb_en(wb_en), .wb_address(wb_address), .wb_data(wb_data),
      .ld_valid(ld_valid), .ld_address(ld_address), .ld_data(ld_data), .ld_ready(ld_ready),
      .src1(src1), .src2(src2), .two_src(two_src),
      .reg_file_wb_en(reg_file_wb_en), .reg_file_wb_address(reg_file_wb_address),
      .reg_file_wb_data(reg_file_wb_data),
      .pending_hazard(pending_hazard), .stall_req(stall_req)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  a;
      logic [31:0] d;
      bit          v;
   } ent_t;

   ent_t        q[$];
   bit          m_en, m_fifo, m_hold;
   logic [3:0]  m_addr;
   logic [31:0] m_data;
   int          m_starve;
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_en = 0; m_fifo = 0; m_hold = 0; m_starve = 0;
      m_addr = '0; m_data = '0;
   endtask

   function automatic bit exp_hazard();
      bit h = 0;
      foreach (q[i])
         if (q[i].v && (q[i].a == src1 || (two_src && q[i].a == src2))) h = 1;
      if (m_en && m_fifo && (m_addr == src1 || (two_src && m_addr == src2))) h = 1;
      return h;
   endfunction

   function automatic bit exp_stall();
      return (m_starve == LIM) || (q.size() == DEPTH) ||
             (m_hold && !(q.size() == 0 && m_starve == 0));
   endfunction

   // Entered just after a falling edge with inputs set; checks, advances the model, returns at next falling edge.
   task automatic cycle();
      bit   st, acc, hv;
      ent_t e, h;
      #1;
      check_eq("ld_ready", ld_ready, q.size() < DEPTH);
      check_eq("pending_hazard", pending_hazard, exp_hazard());
      st = exp_stall();
      check_eq("stall_req", stall_req, st);
      check_eq("wb_en_out", reg_file_wb_en, m_en);
      if (m_en) begin
         check_eq("wb_addr_out", reg_file_wb_address, m_addr);
         check_eq("wb_data_out", reg_file_wb_data, m_data);
      end
      acc = ld_valid && q.size() < DEPTH;
      hv  = q.size() > 0 && q[0].v;
      if (q.size() == 0 || !wb_en) m_starve = 0;
      else if (hv && m_starve < LIM) m_starve++;
      m_hold = st;
      m_en = 0; m_fifo = 0;
      if (wb_en) begin
         m_en = 1; m_addr = wb_address; m_data = wb_data;
         foreach (q[i]) if (q[i].a == wb_address) q[i].v = 0;
      end else if (q.size() > 0) begin
         h = q.pop_front();
         if (h.v) begin
            m_en = 1; m_fifo = 1; m_addr = h.a; m_data = h.d;
         end
      end
      if (acc) begin
         e.a = ld_address; e.d = ld_data;
         e.v = !(wb_en && wb_address == ld_address);
         q.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic drive(input bit we, input logic [3:0] wa, input logic [31:0] wd,
                        input bit lv, input logic [3:0] la, input logic [31:0] ldd,
                        input logic [3:0] s1, input logic [3:0] s2, input bit two);
      wb_en = we; wb_address = wa; wb_data = wd;
      ld_valid = lv; ld_address = la; ld_data = ldd;
      src1 = s1; src2 = s2; two_src = two;
      cycle();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic reset_pulse();
      rst = 0;
      #1;
      check_eq("rst_wb_en", reg_file_wb_en, 1'b0);
      check_eq("rst_wb_addr", reg_file_wb_address, 4'h0);
      check_eq("rst_wb_data", reg_file_wb_data, 32'h0);
      check_eq("rst_ld_ready", ld_ready, 1'b1);
      check_eq("rst_stall", stall_req, 1'b0);
      check_eq("rst_hazard", pending_hazard, 1'b0);
      model_reset();
      @(negedge clk);
      rst = 1;
   endtask

   initial begin
      rst = 1;
      wb_en = 1; wb_address = '1; wb_data = '1;
      ld_valid = 1; ld_address = '1; ld_data = '1;
      src1 = '1; src2 = '1; two_src = 1;
      @(negedge clk);
      reset_pulse();
      @(negedge clk);
      reset_pulse();
      idle(2);

      // idle port: single load return
      drive(0, 0, 0, 1, 3, 32'hAAAA0001, 3, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 3, 0, 0);
      wb_en = 0; ld_valid = 0; src1 = 3;
      #1;
      check_eq("idle_write_en", reg_file_wb_en, 1'b1);
      check_eq("idle_write_addr", reg_file_wb_address, 4'd3);
      check_eq("idle_write_data", reg_file_wb_data, 32'hAAAA0001);
      check_eq("idle_write_hazard", pending_hazard, 1'b1);
      cycle();
      idle(1);

      // contention: primary r1..r4 while r5, r6 queue
      drive(1, 1, 32'h101, 1, 5, 32'h505, 0, 0, 0);
      drive(1, 2, 32'h102, 1, 6, 32'h606, 0, 0, 0);
      drive(1, 3, 32'h103, 0, 0, 0, 0, 0, 0);
      drive(1, 4, 32'h104, 0, 0, 0, 0, 0, 0);
      idle(4);

      // WAW squash
      drive(1, 1, 32'h1, 1, 7, 32'h11, 7, 0, 0);
      drive(1, 7, 32'h22, 0, 0, 0, 7, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 7, 0, 0);
      idle(3);

      // starvation
      drive(1, 1, 32'h5, 1, 8, 32'h88, 0, 0, 0);
      for (int i = 0; i < 11; i++) drive(1, 2, i, 0, 0, 0, 0, 0, 0);
      idle(5);

      // two_src gating
      drive(1, 1, 32'h7, 1, 9, 32'h99, 0, 9, 1);
      drive(1, 1, 32'h7, 0, 0, 0, 0, 9, 1);
      drive(1, 1, 32'h7, 0, 0, 0, 0, 9, 0);
      idle(3);

      // randomized traffic in three contention phases
      for (int ph = 0; ph < 3; ph++) begin
         for (int i = 0; i < 200; i++) begin
            int unsigned wp;
            wp = (ph == 0) ? 30 : (ph == 1) ? 90 : 60;
            if ($urandom_range(0, 99) == 0) begin
               reset_pulse();
            end else begin
               drive($urandom_range(0, 99) < wp, 4'($urandom_range(0, 3)), $urandom,
                     $urandom_range(0, 99) < 60,
                     ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3)),
                     $urandom, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                     1'($urandom));
            end
         end
      end
      idle(12);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port between the primary WB-stage writer and a secondary late-result writer (multi-cycle load return). The primary writer is never backpressured. Secondary writes use a valid/ready handshake, are buffered in a small FIFO and drained into idle write-port cycles. The block also tells the decode-stage hazard logic when a decoded source register has a write still pending in the arbiter. It sits between the WB stage, the memory unit and the register file write port.

## Interface
- REGISTER_LEN, 32, data width
- REG_ADDRESS_LEN, 4, register address width
- DEPTH, 2, secondary FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 8, cycles the FIFO head may wait before stall_req is asserted

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- wb_en  in  1  primary write request; always served
- wb_address  in  REG_ADDRESS_LEN  primary destination
- wb_data  in  REGISTER_LEN  primary data
- ld_valid  in  1  secondary request valid
- ld_address  in  REG_ADDRESS_LEN  secondary destination
- ld_data  in  REGISTER_LEN  secondary data
- ld_ready  out  1  secondary accept; equals ~full
- src1, src2  in  REG_ADDRESS_LEN  decode-stage source registers
- two_src  in  1  src2 is a real operand
- reg_file_wb_en  out  1  registered write enable to the register file
- reg_file_wb_address  out  REG_ADDRESS_LEN  registered write address
- reg_file_wb_data  out  REGISTER_LEN  registered write data
- pending_hazard  out  1  src1 or src2 (if two_src) matches a pending secondary write
- stall_req  out  1  request to bubble the pipeline so the FIFO can drain

## Operation
- A secondary write is accepted when ld_valid & ld_ready. It is enqueued at the tail with a valid bit.
- Ordering contract: every secondary write is older than every primary write occurring in or after its acceptance cycle.
- Grant each cycle:
  - If wb_en is high, the primary write goes to the output register.
  - Otherwise, if the FIFO head is valid, the head is popped to the output register.
  - Otherwise the output enable is 0.
- WAW squash: when wb_en is high, every valid FIFO entry with address == wb_address is invalidated.
  - An entry accepted in the same cycle with the same address is accepted (handshake completes) but enqueued invalid.
- An invalid head is popped without writing. This costs one cycle and produces no write.
- Multiple secondary entries to the same address are all kept and written in FIFO order.
- pending_hazard is combinational. It is high if any valid FIFO entry, or the output register holding a FIFO-sourced write, matches src1, or matches src2 with two_src=1.
- Register 0 gets no special treatment.
- Starvation counter:
  - Counts consecutive cycles the head is valid and not popped.
  - Clears on pop or when the FIFO is empty; saturates at STARVE_LIMIT.
  - stall_req = (counter == STARVE_LIMIT) | full. It stays high until the FIFO is empty and the counter is 0.
- Occupancy count width is clog2(DEPTH)+1. full = (count == DEPTH), empty = (count == 0). Pointers wrap modulo DEPTH.

## Timing
- Reset (rst=0, asynchronous) values:
  - reg_file_wb_en=0, reg_file_wb_address=0, reg_file_wb_data=0.
  - FIFO empty, all valid bits 0, counter 0, ld_ready=1, stall_req=0.
  - pending_hazard follows the now-empty state, so it is 0.
- Reset mid-operation discards all queued writes. No register-file write occurs while rst=0.
- Primary latency: wb_en at edge N appears on reg_file_wb_en after edge N+1.
- Secondary latency with idle primary and empty FIFO: accept at edge N, pop at edge N+1, write visible after edge N+2.
- ld_ready depends only on registered occupancy. When the FIFO is full, an accept is refused even in a cycle that pops.
- Enqueue and pop in the same cycle: occupancy is unchanged.
- A squash takes effect on the same edge as the primary grant.

## Test plan
- Reset: hold rst=0 while driving all inputs high → all outputs 0 except ld_ready=1. Release → no write for 2 cycles.
- Idle port: ld write to r3=0xAAAA0001 with wb_en=0 → reg_file_wb_en=1, address 3, data 0xAAAA0001 two edges after accept. pending_hazard with src1=3 is high through that write cycle.
- Contention: wb_en=1 for 4 cycles (r1..r4) while ld writes r5 and r6 are accepted → writes r1,r2,r3,r4,r5,r6 in that order. After the second accept ld_ready=0.
- WAW squash: queue ld r7=0x11, then wb_en to r7=0x22 → only 0x22 is written to r7. pending_hazard(src1=7) drops after the squash.
- Starvation: wb_en held high for 12 cycles with one queued entry → stall_req rises after 8 waiting cycles (STARVE_LIMIT=8). After wb_en drops, it clears once the FIFO drains.
- two_src gating: queue ld to r9, src2=9, src1=0 → pending_hazard=1 with two_src=1 and 0 with two_src=0.
